// File: rtl/fila_pedidos.sv
// fila_pedidos: debounced order queue that launches coffee brews and counts completed ones
module fila_pedidos #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_PEDIDOS     = 7,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       botao,
    input  logic       cancelar,
    input  logic [3:0] state,
    output logic       start,
    output logic [2:0] pendentes,
    output logic       cheio,
    output logic [7:0] servidos,
    output logic       erro_timeout
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0] MAX = 3'(MAX_PEDIDOS);

    typedef enum logic [1:0] {OCIOSO, DISPARO, AGUARDA_FIM} fsm_t;

    fsm_t          fsm, fsm_nxt;
    logic          sync1, sync2, nivel, nivel_d, pedido, lancar;
    logic          viu_extracao, viu_nxt, erro_nxt;
    logic [DW-1:0] deb_cnt;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic [2:0]    pend_nxt;
    logic [7:0]    serv_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            nivel   <= 1'b0;
            nivel_d <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync1   <= botao;
            sync2   <= sync1;
            nivel_d <= nivel;
            if (sync2 == nivel)
                deb_cnt <= '0;
            else if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                nivel   <= sync2;
                deb_cnt <= '0;
            end else
                deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign pedido = nivel & ~nivel_d;

    always_comb begin
        fsm_nxt  = fsm;
        tmo_nxt  = tmo_cnt;
        viu_nxt  = viu_extracao;
        erro_nxt = erro_timeout;
        serv_nxt = servidos;
        lancar   = 1'b0;
        case (fsm)
            OCIOSO: begin
                tmo_nxt = '0;
                if (pendentes != 3'd0 && state == 4'd1 && !cancelar)
                    fsm_nxt = DISPARO;
            end
            DISPARO: begin
                tmo_nxt = tmo_cnt + 1'b1;
                // the machine has already started, so state 2 wins over cancelar
                if (state == 4'd2) begin
                    lancar  = 1'b1;
                    fsm_nxt = AGUARDA_FIM;
                end else if (cancelar)
                    fsm_nxt = OCIOSO;
                else if (tmo_nxt == TW'(TIMEOUT_CYCLES)) begin
                    erro_nxt = 1'b1;
                    fsm_nxt  = OCIOSO;
                end
            end
            AGUARDA_FIM: begin
                if (state == 4'd9)
                    viu_nxt = 1'b1;
                if (state == 4'd1) begin
                    fsm_nxt  = OCIOSO;
                    viu_nxt  = 1'b0;
                    serv_nxt = servidos + {7'd0, viu_extracao && servidos != 8'hFF};
                end
            end
            default: fsm_nxt = OCIOSO;
        endcase
        pend_nxt = cancelar                        ? 3'd0 :
                   (pedido && lancar)              ? pendentes :
                   (pedido && pendentes < MAX)     ? pendentes + 3'd1 :
                   lancar                          ? pendentes - 3'd1 : pendentes;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm          <= OCIOSO;
            start        <= 1'b0;
            tmo_cnt      <= '0;
            viu_extracao <= 1'b0;
            erro_timeout <= 1'b0;
            servidos     <= 8'd0;
            pendentes    <= 3'd0;
            cheio        <= 1'b0;
        end else begin
            fsm          <= fsm_nxt;
            start        <= fsm_nxt == DISPARO;
            tmo_cnt      <= tmo_nxt;
            viu_extracao <= viu_nxt;
            erro_timeout <= erro_nxt;
            servidos     <= serv_nxt;
            pendentes    <= pend_nxt;
            cheio        <= pend_nxt == MAX;
        end
    end
endmodule

// File: tb/tb_fila_pedidos.sv
// tb_fila_pedidos: directed scenario tests for the coffee order queue
module tb_fila_pedidos;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       botao;
    logic       cancelar;
    logic [3:0] state;
    logic       start;
    logic [2:0] pendentes;
    logic       cheio;
    logic [7:0] servidos;
    logic       erro_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int exp_serv = 0;

    fila_pedidos dut (
        .clk(clk), .rst_n(rst_n), .botao(botao), .cancelar(cancelar), .state(state),
        .start(start), .pendentes(pendentes), .cheio(cheio), .servidos(servidos),
        .erro_timeout(erro_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press();
        botao = 1'b1;
        repeat (8) tick();
        botao = 1'b0;
        repeat (8) tick();
    endtask

    // machine model from state 2 onward: walk 3..last one cycle each, then back to IDLE
    task automatic run_from(input int last);
        for (int s = 3; s <= last; s++) begin
            tick();
            state = 4'(s);
        end
        tick();
        state = 4'd1;
        tick();
    endtask

    task automatic brew(input int last);
        int n = 0;
        state = 4'd1;
        while (!start && n < 50) begin
            tick();
            n++;
        end
        n_cmp++;
        if (start !== 1'b1) begin
            n_err++;
            $display("FAIL brew_start_wait: start=%0b required 1 within 50 cycles", start);
        end
        tick();
        state = 4'd2;
        tick();
        run_from(last);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; botao = 1'b0; cancelar = 1'b0; state = 4'd5;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if ({start, pendentes, cheio, servidos, erro_timeout} !== 14'd0) begin
            n_err++;
            $display("FAIL reset: start=%0b pend=%0d cheio=%0b serv=%0d erro=%0b required all 0",
                     start, pendentes, cheio, servidos, erro_timeout);
        end
    endtask

    task automatic test_single_press();
        int hi = 0;
        state = 4'd1;
        botao = 1'b1; tick(); botao = 1'b0; tick();
        botao = 1'b1; tick(); botao = 1'b0; tick();
        botao = 1'b1;
        repeat (6) tick();
        n_cmp++;
        if (pendentes !== 3'd0) begin
            n_err++; $display("FAIL press_edge6: pend=%0d required 0", pendentes);
        end
        tick();
        n_cmp++;
        if (pendentes !== 3'd1) begin
            n_err++; $display("FAIL press_edge7: pend=%0d required 1", pendentes);
        end
        tick();
        hi += start;
        tick();
        hi += start;
        state = 4'd2;
        tick();
        hi += start;
        n_cmp++;
        if (hi !== 2) begin
            n_err++; $display("FAIL start_width: high=%0d cycles required 2", hi);
        end
        n_cmp++;
        if (pendentes !== 3'd0) begin
            n_err++; $display("FAIL launch_dec: pend=%0d required 0", pendentes);
        end
        run_from(9);
        exp_serv++;
        botao = 1'b0;
        repeat (10) tick();
        n_cmp++;
        if (servidos !== 8'(exp_serv) || pendentes !== 3'd0 || start !== 1'b0) begin
            n_err++;
            $display("FAIL single_done: serv=%0d pend=%0d start=%0b required %0d 0 0",
                     servidos, pendentes, start, exp_serv);
        end
    endtask

    task automatic test_overflow();
        state = 4'd5;
        for (int i = 1; i <= 9; i++) begin
            press();
            n_cmp++;
            if (pendentes !== 3'((i > 7) ? 7 : i) || cheio !== (i >= 7)) begin
                n_err++;
                $display("FAIL overflow_%0d: pend=%0d cheio=%0b required %0d %0b",
                         i, pendentes, cheio, (i > 7) ? 7 : i, i >= 7);
            end
        end
        cancelar = 1'b1; tick(); cancelar = 1'b0;
        n_cmp++;
        if (pendentes !== 3'd0 || cheio !== 1'b0) begin
            n_err++; $display("FAIL cancel_clear: pend=%0d cheio=%0b required 0 0", pendentes, cheio);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        state = 4'd5;
        press();
        state = 4'd1;
        tick();
        n_cmp++;
        if (start !== 1'b1 || erro_timeout !== 1'b0) begin
            n_err++; $display("FAIL timeout_enter: start=%0b erro=%0b required 1 0", start, erro_timeout);
        end
        while (start && n < 40) begin
            n++;
            tick();
        end
        n_cmp++;
        if (n !== 16) begin
            n_err++; $display("FAIL timeout_len: start high %0d cycles required 16", n);
        end
        n_cmp++;
        if (erro_timeout !== 1'b1 || pendentes !== 3'd1) begin
            n_err++; $display("FAIL timeout_flag: erro=%0b pend=%0d required 1 1", erro_timeout, pendentes);
        end
        tick();
        n_cmp++;
        if (start !== 1'b1) begin
            n_err++; $display("FAIL timeout_retry: start=%0b required 1", start);
        end
        state = 4'd5; cancelar = 1'b1; tick(); cancelar = 1'b0;
        n_cmp++;
        if (start !== 1'b0 || pendentes !== 3'd0 || erro_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL cancel_disparo: start=%0b pend=%0d erro=%0b required 0 0 1",
                     start, pendentes, erro_timeout);
        end
    endtask

    task automatic test_back_to_back();
        state = 4'd5;
        press();
        press();
        botao = 1'b1;
        repeat (4) tick();
        state = 4'd1;
        tick();
        tick();
        state = 4'd2;
        tick();
        n_cmp++;
        if (pendentes !== 3'd2 || start !== 1'b0) begin
            n_err++; $display("FAIL press_on_launch: pend=%0d start=%0b required 2 0", pendentes, start);
        end
        run_from(9);
        exp_serv++;
        botao = 1'b0;
        tick();
        n_cmp++;
        if (start !== 1'b1 || servidos !== 8'(exp_serv)) begin
            n_err++; $display("FAIL relaunch: start=%0b serv=%0d required 1 %0d", start, servidos, exp_serv);
        end
        tick();
        state = 4'd2; cancelar = 1'b1;
        tick();
        cancelar = 1'b0;
        n_cmp++;
        if (pendentes !== 3'd0 || start !== 1'b0) begin
            n_err++; $display("FAIL cancel_on_launch: pend=%0d start=%0b required 0 0", pendentes, start);
        end
        run_from(9);
        exp_serv++;
        n_cmp++;
        if (servidos !== 8'(exp_serv)) begin
            n_err++; $display("FAIL brew_after_cancel: serv=%0d required %0d", servidos, exp_serv);
        end
    endtask

    task automatic test_abort();
        state = 4'd5;
        press();
        brew(4);
        tick();
        n_cmp++;
        if (servidos !== 8'(exp_serv) || pendentes !== 3'd0 || start !== 1'b0) begin
            n_err++;
            $display("FAIL abort: serv=%0d pend=%0d start=%0b required %0d 0 0",
                     servidos, pendentes, start, exp_serv);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 256; i++) begin
            state = 4'd5;
            press();
            brew(9);
            exp_serv = (exp_serv < 255) ? exp_serv + 1 : 255;
            n_cmp++;
            if (servidos !== 8'(exp_serv)) begin
                n_err++; $display("FAIL servidos_sat_%0d: serv=%0d required %0d", i, servidos, exp_serv);
            end
        end
    endtask

    task automatic test_reset_mid();
        state = 4'd5;
        press();
        press();
        state = 4'd1;
        tick();
        tick();
        n_cmp++;
        if (start !== 1'b1 || servidos !== 8'd255 || erro_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset: start=%0b serv=%0d erro=%0b required 1 255 1",
                     start, servidos, erro_timeout);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({start, pendentes, cheio, servidos, erro_timeout} !== 14'd0) begin
            n_err++;
            $display("FAIL async_reset: start=%0b pend=%0d cheio=%0b serv=%0d erro=%0b required all 0",
                     start, pendentes, cheio, servidos, erro_timeout);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_overflow();
        test_timeout();
        test_back_to_back();
        test_abort();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
